// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and pointer-width derivation.
package fifo_pkg;

    localparam int unsigned CONV_W = 32;

    // Pointer width carries one wrap bit above the RAM address.
    function automatic int unsigned ptr_w(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

    // Callers zero-extend narrower vectors to CONV_W and truncate the result.
    function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] w);
        return w ^ (w >> 1);
    endfunction

    // Prefix XOR from the MSB down, done in log2(CONV_W) doubling steps.
    function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] w);
        logic [CONV_W-1:0] b;
        b = w;
        for (int i = 0; i < 5; i++) begin
            b = b ^ (b >> (1 << i));
        end
        return b;
    endfunction

endpackage

// File: rtl/b2g.sv
// Binary-to-Gray converter, parametrised by width.
module b2g
    import fifo_pkg::*;
#(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] bin,
    output logic [W-1:0] gray
);

    assign gray = W'(bin2gray(CONV_W'(bin)));

endmodule

// File: rtl/g2b.sv
// Gray-to-binary converter, parametrised by width; shared with the read-side block.
module g2b
    import fifo_pkg::*;
#(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    assign bin = W'(gray2bin(CONV_W'(gray)));

endmodule

// File: rtl/wptr_ctrl_param.sv
// Write-domain pointer controller for the async FIFO: address, Gray pointer,
// read-pointer synchroniser and full / almost-full / level / overflow flags.
module wptr_ctrl_param
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AF_LEVEL    = 12
) (
    input  logic              wclk,
    input  logic              wrst_n,
    input  logic              w_en,
    input  logic              ovf_clr,
    input  logic [ADDR_W:0]   g_rptr,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W:0]   wptr,
    output logic              w_accept,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   wlevel,
    output logic              overflow
);

    localparam int unsigned PTR_W = ptr_w(ADDR_W);

    logic [PTR_W-1:0] wbin;
    logic [PTR_W-1:0] wbin_next;
    logic [PTR_W-1:0] gnext;
    logic [PTR_W-1:0] rq;
    logic [PTR_W-1:0] rbin_s;
    logic [PTR_W-1:0] level_next;
    logic             full_next;

    // Keep the sync_rptr_ prefix: timing constraints match on it.
    logic [PTR_W-1:0] sync_rptr_q [SYNC_STAGES];

    assign w_accept  = w_en & ~full;
    assign wbin_next = wbin + PTR_W'(w_accept);
    assign rq        = sync_rptr_q[SYNC_STAGES-1];
    assign waddr     = wbin[ADDR_W-1:0];

    b2g #(.W(PTR_W)) u_b2g (
        .bin  (wbin_next),
        .gray (gnext)
    );

    g2b #(.W(PTR_W)) u_g2b (
        .gray (rq),
        .bin  (rbin_s)
    );

    // Full when the next write pointer sits exactly one lap ahead of the read pointer.
    assign level_next = wbin_next - rbin_s;
    assign full_next  = (gnext == {~rq[ADDR_W:ADDR_W-1], rq[ADDR_W-2:0]});

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_rptr_q[i] <= '0;
            end
        end else begin
            sync_rptr_q[0] <= g_rptr;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_rptr_q[i] <= sync_rptr_q[i-1];
            end
        end
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wbin        <= '0;
            wptr        <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wlevel      <= '0;
            overflow    <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wptr        <= gnext;
            full        <= full_next;
            almost_full <= (level_next >= PTR_W'(AF_LEVEL));
            wlevel      <= level_next;
            // A rejected write outranks a same-cycle clear.
            if (w_en && full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
